// File: rtl/cntr_cmd_pkg.sv
// Shared opcode/state encodings and default width for the counter command controller.
package cntr_cmd_pkg;

  localparam int unsigned CNTR_N_DEF = 8;
  localparam int unsigned CMD_OP_W   = 3;

  typedef enum logic [CMD_OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_PRESET = 3'd1,
    OP_RUN_UP = 3'd2,
    OP_RUN_DN = 3'd3,
    OP_PAUSE  = 3'd4,
    OP_RESUME = 3'd5,
    OP_ABORT  = 3'd6,
    OP_RSVD   = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN_UP = 3'd2,
    ST_RUN_DN = 3'd3,
    ST_PAUSED = 3'd4
  } state_e;

  // Opcodes that only make sense from IDLE (plus the reserved code) are errors once a run is active.
  function automatic logic op_bad_when_active(cmd_op_e op);
    return (op == OP_PRESET) || (op == OP_RUN_UP) || (op == OP_RUN_DN) || (op == OP_RSVD);
  endfunction

  function automatic logic op_bad_when_idle(cmd_op_e op);
    return (op == OP_PAUSE) || (op == OP_RESUME) || (op == OP_RSVD);
  endfunction

endpackage

// File: rtl/cntr_irq_latch.sv
// Sticky completion interrupt; set wins over clear. Built only with CNTR_CMD_IRQ_EN.
`ifdef CNTR_CMD_IRQ_EN
module cntr_irq_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic irq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (set) begin
      irq <= 1'b1;
    end else if (clr) begin
      irq <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/cntr_cmd_ctrl.sv
// Command front-end for multifunction_counter: preset load, run up/down, pause/resume, abort.
// Optional sticky completion interrupt (irq/irq_clr) when CNTR_CMD_IRQ_EN is defined.
module cntr_cmd_ctrl
  import cntr_cmd_pkg::*;
#(
  parameter int unsigned N = CNTR_N_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_OP_W-1:0] cmd_op,
  input  logic [N-1:0]        cmd_data,
  input  logic                ctr_expired,
  output logic                enable_cnt_up,
  output logic                enable_cnt_dn,
  output logic                new_cntr_preset,
  output logic [N-1:0]        new_cntr_preset_value,
  output logic                pause_counting,
  output logic                busy,
  output logic                done,
  output logic                cmd_err
`ifdef CNTR_CMD_IRQ_EN
  ,
  output logic                irq,
  input  logic                irq_clr
`endif
);

  state_e  state;
  cmd_op_e op;
  logic    accept;
  logic    running;
  logic    active;
  logic    finish;
  logic    bad_cmd;

  assign op      = cmd_op_e'(cmd_op);
  assign accept  = cmd_valid & cmd_ready;
  assign running = (state == ST_RUN_UP) || (state == ST_RUN_DN);
  assign active  = running || (state == ST_PAUSED);

  // Expiry beats a same-cycle PAUSE/ABORT; either way the run ends with one done pulse.
  assign finish  = (running & ctr_expired) | (active & accept & (op == OP_ABORT));
  assign bad_cmd = accept & ((state == ST_IDLE) ? op_bad_when_idle(op)
                                                : (active & op_bad_when_active(op)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      cmd_ready             <= 1'b0;
      enable_cnt_up         <= 1'b0;
      enable_cnt_dn         <= 1'b0;
      new_cntr_preset       <= 1'b0;
      new_cntr_preset_value <= '0;
      pause_counting        <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      cmd_err               <= 1'b0;
    end else begin
      cmd_ready       <= 1'b1;
      new_cntr_preset <= 1'b0;
      done            <= finish;
      cmd_err         <= bad_cmd;
      if (finish) begin
        state          <= ST_IDLE;
        enable_cnt_up  <= 1'b0;
        enable_cnt_dn  <= 1'b0;
        pause_counting <= 1'b0;
        busy           <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              case (op)
                OP_PRESET: begin
                  new_cntr_preset_value <= cmd_data;
                  new_cntr_preset       <= 1'b1;
                  cmd_ready             <= 1'b0;
                  busy                  <= 1'b1;
                  state                 <= ST_LOAD;
                end
                OP_RUN_UP: begin
                  enable_cnt_up <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_RUN_UP;
                end
                OP_RUN_DN: begin
                  enable_cnt_dn <= 1'b1;
                  busy          <= 1'b1;
                  state         <= ST_RUN_DN;
                end
                default: ;
              endcase
            end
          end
          ST_LOAD: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          ST_RUN_UP, ST_RUN_DN: begin
            if (accept && (op == OP_PAUSE)) begin
              pause_counting <= 1'b1;
              state          <= ST_PAUSED;
            end
          end
          ST_PAUSED: begin
            // Direction to resume is remembered by whichever enable is still held.
            if (accept && (op == OP_RESUME)) begin
              pause_counting <= 1'b0;
              state          <= enable_cnt_up ? ST_RUN_UP : ST_RUN_DN;
            end
          end
          default: begin
            state          <= ST_IDLE;
            enable_cnt_up  <= 1'b0;
            enable_cnt_dn  <= 1'b0;
            pause_counting <= 1'b0;
            busy           <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CNTR_CMD_IRQ_EN
  cntr_irq_latch u_irq_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (done),
    .clr   (irq_clr),
    .irq   (irq)
  );
`endif

endmodule

// File: tb/tb_cntr_cmd_ctrl.sv
// Self-checking bench for cntr_cmd_ctrl: behavioural model, directed scenarios, random traffic.
module tb_cntr_cmd_ctrl;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [N-1:0] cmd_data = '0;
  logic         ctr_expired = 1'b0;
  logic         enable_cnt_up;
  logic         enable_cnt_dn;
  logic         new_cntr_preset;
  logic [N-1:0] new_cntr_preset_value;
  logic         pause_counting;
  logic         busy;
  logic         done;
  logic         cmd_err;
`ifdef CNTR_CMD_IRQ_EN
  logic         irq;
  logic         irq_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  cntr_cmd_ctrl #(.N(N)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_data              (cmd_data),
    .ctr_expired           (ctr_expired),
    .enable_cnt_up         (enable_cnt_up),
    .enable_cnt_dn         (enable_cnt_dn),
    .new_cntr_preset       (new_cntr_preset),
    .new_cntr_preset_value (new_cntr_preset_value),
    .pause_counting        (pause_counting),
    .busy                  (busy),
    .done                  (done),
    .cmd_err               (cmd_err)
`ifdef CNTR_CMD_IRQ_EN
    ,
    .irq                   (irq),
    .irq_clr               (irq_clr)
`endif
  );

  // Model: run direction (0 none, 1 up, 2 down), paused flag, one-cycle load phase.
  int unsigned  m_dir;
  bit           m_paused, m_loading, m_ready, m_done, m_err, m_irq;
  logic [N-1:0] m_val;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_up = 0, cnt_dn = 0, cnt_pause = 0, cnt_done = 0, cnt_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_paused = 0; m_loading = 0; m_ready = 0;
    m_done = 0; m_err = 0; m_irq = 0; m_val = '0;
  endtask

  task automatic model_step();
    bit acc;
    acc = cmd_valid && m_ready;
`ifdef CNTR_CMD_IRQ_EN
    m_irq = m_done ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
`endif
    m_done = 0;
    m_err  = 0;
    if (m_loading) begin
      m_loading = 0;
    end else if (m_dir == 0) begin
      if (acc) begin
        case (cmd_op)
          3'd1: begin m_val = cmd_data; m_loading = 1; end
          3'd2: m_dir = 1;
          3'd3: m_dir = 2;
          3'd4, 3'd5, 3'd7: m_err = 1;
          default: ;
        endcase
      end
    end else begin
      if (acc && (cmd_op inside {3'd1, 3'd2, 3'd3, 3'd7})) m_err = 1;
      if (!m_paused && ctr_expired) begin
        m_dir = 0; m_done = 1;
      end else if (acc && cmd_op == 3'd6) begin
        m_dir = 0; m_paused = 0; m_done = 1;
      end else if (acc && cmd_op == 3'd4) begin
        m_paused = 1;
      end else if (acc && cmd_op == 3'd5) begin
        m_paused = 0;
      end
    end
    m_ready = !m_loading;
  endtask

  // One clock: model advances on the rising edge, DUT is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("enable_cnt_up", 32'(enable_cnt_up), 32'(m_dir == 1));
    chk("enable_cnt_dn", 32'(enable_cnt_dn), 32'(m_dir == 2));
    chk("new_cntr_preset", 32'(new_cntr_preset), 32'(m_loading));
    chk("preset_value", 32'(new_cntr_preset_value), 32'(m_val));
    chk("pause_counting", 32'(pause_counting), 32'(m_paused));
    chk("busy", 32'(busy), 32'((m_dir != 0) || m_loading));
    chk("done", 32'(done), 32'(m_done));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("one_hot_enable", 32'(enable_cnt_up & enable_cnt_dn), 32'd0);
`ifdef CNTR_CMD_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
    cnt_up    += int'(enable_cnt_up);
    cnt_dn    += int'(enable_cnt_dn);
    cnt_pause += int'(pause_counting);
    cnt_done  += int'(done);
    cnt_err   += int'(cmd_err);
  endtask

  task automatic send(input logic [2:0] op, input logic [N-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  int base;

  initial begin
    model_reset();
    repeat (3) tick();
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_value", 32'(new_cntr_preset_value), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Preset load: one-cycle strobe, ready low during load, value held afterwards.
    send(3'd1, 8'd200);
    chk("preset_strobe", 32'(new_cntr_preset), 32'd1);
    chk("preset_value_200", 32'(new_cntr_preset_value), 32'd200);
    chk("preset_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("preset_strobe_end", 32'(new_cntr_preset), 32'd0);
    chk("preset_value_hold", 32'(new_cntr_preset_value), 32'd200);

    // Run up, expiry after 20 enabled cycles.
    base = cnt_up;
    send(3'd2, '0);
    repeat (19) tick();
    ctr_expired = 1'b1;
    tick();
    ctr_expired = 1'b0;
    chk("run_up_cycles", 32'(cnt_up - base), 32'd20);
    chk("run_up_done", 32'(done), 32'd1);
    chk("run_up_idle", 32'(busy), 32'd0);
    base = cnt_done;
    tick();
    chk("run_up_done_once", 32'(cnt_done - base), 32'd0);
`ifdef CNTR_CMD_IRQ_EN
    chk("irq_set", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq), 32'd0);
`endif

    // Run down, pause for 10 cycles, resume.
    base = cnt_pause;
    send(3'd3, '0);
    repeat (4) tick();
    send(3'd4, '0);
    repeat (9) tick();
    send(3'd5, '0);
    chk("pause_cycles", 32'(cnt_pause - base), 32'd10);
    chk("resumed_dn", 32'({enable_cnt_dn, enable_cnt_up, pause_counting}), 32'b100);

    // Illegal commands in a run, then expiry coincident with abort.
    send(3'd6, '0);
    tick();
    send(3'd2, '0);
    send(3'd1, 8'h55);
    chk("preset_in_run_err", 32'(cmd_err), 32'd1);
    chk("preset_in_run_kept", 32'({enable_cnt_up, new_cntr_preset_value}), 32'h1C8);
    send(3'd7, '0);
    chk("rsvd_err", 32'(cmd_err), 32'd1);
    base = cnt_done;
    ctr_expired = 1'b1;
    send(3'd6, '0);
    ctr_expired = 1'b0;
    chk("expire_abort_done", 32'(done), 32'd1);
    chk("expire_abort_no_err", 32'(cmd_err), 32'd0);
    tick();
    chk("expire_abort_single", 32'(cnt_done - base), 32'd1);

    // Asynchronous reset mid run: enables drop before any clock edge, no done.
    send(3'd2, '0);
    tick();
    base = cnt_done;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_up", 32'(enable_cnt_up), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    chk("async_rst_no_done", 32'(cnt_done - base), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid   = ($urandom_range(0, 2) != 0);
      cmd_op      = 3'($urandom_range(0, 7));
      cmd_data    = N'($urandom);
      ctr_expired = ($urandom_range(0, 11) == 0);
`ifdef CNTR_CMD_IRQ_EN
      irq_clr     = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    cmd_valid   = 1'b0;
    ctr_expired = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cntr_cmd_ctrl.md
CNTR_CMD_CTRL -- requirements
Module: cntr_cmd_ctrl

Interface
REQ-001 Parameter N, default 8, counter/preset width in bits; matches the downstream multifunction_counter N.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  command can be accepted; transfer when cmd_valid & cmd_ready.
REQ-006 cmd_op  in  3  opcode: 0 NOP, 1 PRESET, 2 RUN_UP, 3 RUN_DN, 4 PAUSE, 5 RESUME, 6 ABORT, 7 reserved.
REQ-007 cmd_data  in  N  preset value (PRESET only).
REQ-008 ctr_expired  in  1  expiry flag from the counter.
REQ-009 enable_cnt_up / enable_cnt_dn  out  1 each  counter direction enables.
REQ-010 new_cntr_preset  out  1  preset load strobe.
REQ-011 new_cntr_preset_value  out  N  registered preset value.
REQ-012 pause_counting  out  1  counter hold.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on run completion or abort.
REQ-015 cmd_err  out  1  one-cycle pulse on an illegal or reserved command.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN_UP, RUN_DN, PAUSED; all outputs registered.
REQ-017 cmd_ready SHALL be 1 in IDLE, RUN_UP, RUN_DN, PAUSED and 0 in LOAD, with no combinational dependence on cmd_valid/cmd_op.
REQ-018 IDLE + PRESET SHALL latch cmd_data into new_cntr_preset_value, go to LOAD, and assert new_cntr_preset for exactly 1 cycle, then return to IDLE.
REQ-019 IDLE + RUN_UP/RUN_DN SHALL assert the matching enable the next cycle and hold it; only one enable is high at any time.
REQ-020 In RUN_x, ctr_expired sampled high SHALL clear the enable and pause_counting next cycle, pulse done, and return to IDLE.
REQ-021 RUN_x + PAUSE SHALL set pause_counting, keep the enable, and enter PAUSED; PAUSED + RESUME SHALL clear pause_counting and return to the saved RUN_x.
REQ-022 ABORT in RUN_x or PAUSED SHALL clear both enables and pause_counting, pulse done, and go to IDLE; ABORT in IDLE SHALL be a NOP.
REQ-023 In PAUSED, ctr_expired SHALL be ignored.
REQ-024 NOP SHALL be accepted with no effect in any state; opcode 7, and PRESET/RUN_x in non-IDLE states or PAUSE/RESUME in IDLE, SHALL be consumed with no state change and pulse cmd_err.
REQ-025 Simultaneous ctr_expired and an accepted PAUSE/ABORT in RUN_x: expiry wins, done pulses once, and the command is consumed without cmd_err.
REQ-026 new_cntr_preset_value SHALL hold its last loaded value until the next PRESET.

Reset
REQ-027 On rst_n low: state IDLE, all enables, new_cntr_preset, pause_counting, busy, done, cmd_err = 0; new_cntr_preset_value = 0; cmd_ready = 0 while rst_n is low, and 1 from the first clock after release.
REQ-028 Reset mid-run SHALL drop all enables immediately (asynchronously) without pulsing done.

Configuration
REQ-029 Macro CNTR_CMD_IRQ_EN: when defined, add ports irq (out, 1) and irq_clr (in, 1); irq SHALL set sticky on each done pulse and clear on irq_clr, with set taking priority over clear in the same cycle; reset value 0.
REQ-030 Without CNTR_CMD_IRQ_EN, neither port exists and no associated logic is built.

Structure
REQ-031 Package cntr_cmd_pkg SHALL hold the opcode localparams/enum, the FSM state encoding, and the default N.
REQ-032 Optional sub-module cntr_irq_latch holds the sticky irq; it is instantiated only under CNTR_CMD_IRQ_EN.

Verification
REQ-033 PRESET, cmd_data=8'd200 -> new_cntr_preset high exactly 1 cycle, value 200, cmd_ready low that cycle.
REQ-034 RUN_UP, expiry forced after 20 cycles -> enable_cnt_up high 20 cycles, then low, done pulses once, busy falls.
REQ-035 RUN_DN, PAUSE after 5 cycles, RESUME after 10 -> pause_counting high 10 cycles, enable_cnt_dn held throughout, returns to RUN_DN.
REQ-036 RUN_UP then PRESET, and opcode 7 -> cmd_err pulses each, state unchanged; expiry coincident with ABORT -> single done, no cmd_err.
REQ-037 rst_n low mid RUN_UP -> enable_cnt_up low asynchronously, no done; with CNTR_CMD_IRQ_EN, irq sets on done and clears on irq_clr.
